// File: rtl/regfile_port_ctrl.sv
// Register-file port controller for the multicycle MIPS datapath: operand fetch, writeback sequencing, $0 and read/write hazard handling.
// Build option: define REGFILE_FWD_EN to forward a pending write into the captured operands instead of stalling the request.
module regfile_port_ctrl #(
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_rs,
  input  logic [ADDR_W-1:0] req_rt,
  output logic              op_valid,
  input  logic              op_ready,
  output logic [DATA_W-1:0] opA,
  output logic [DATA_W-1:0] opB,
  input  logic              wb_valid,
  input  logic [ADDR_W-1:0] wb_reg,
  input  logic [DATA_W-1:0] wb_data,
  output logic [ADDR_W-1:0] rf_readRegA,
  output logic [ADDR_W-1:0] rf_readRegB,
  output logic              rf_RegRead,
  input  logic [DATA_W-1:0] rf_regA,
  input  logic [DATA_W-1:0] rf_regB,
  output logic [ADDR_W-1:0] rf_writeReg,
  output logic [DATA_W-1:0] rf_writeData,
  output logic              rf_RegWrite
);

  if (NUM_REGS != (1 << ADDR_W)) begin : gBadCfg
    $error("regfile_port_ctrl: NUM_REGS must equal 2**ADDR_W");
  end

  typedef enum logic [1:0] {IDLE, READ, CAPT} state_t;

  typedef struct packed {
    logic              vld;
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] data;
  } wbPend_t;

  state_t            state, stateNext;
  wbPend_t           wbPend;
  logic              reqReady;
  logic              wbBlock;
  logic              wbTake;
  logic [DATA_W-1:0] nextA, nextB;

  assign wbTake = wb_valid && (wb_reg != '0);

`ifdef REGFILE_FWD_EN
  assign wbBlock = 1'b0;
`else
  // This write will still be pending while READ samples the file; hold the request until it has committed.
  assign wbBlock = wbTake && ((wb_reg == req_rs) || (wb_reg == req_rt));
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    reqReady  = 1'b0;
    case (state)
      IDLE: begin
        reqReady = !wbBlock;
        if (req_valid && reqReady) stateNext = READ;
      end
      READ:    stateNext = CAPT;
      CAPT:    if (op_ready) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_comb begin
    nextA = (rf_readRegA == '0) ? '0 : rf_regA;
    nextB = (rf_readRegB == '0) ? '0 : rf_regB;
`ifdef REGFILE_FWD_EN
    // A write pending in READ commits after the falling-edge read, so the file returns stale data.
    if (wbPend.vld && (rf_readRegA != '0) && (wbPend.rd == rf_readRegA)) nextA = wbPend.data;
    if (wbPend.vld && (rf_readRegB != '0) && (wbPend.rd == rf_readRegB)) nextB = wbPend.data;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rf_readRegA <= '0;
      rf_readRegB <= '0;
      opA         <= '0;
      opB         <= '0;
      wbPend      <= '0;
    end else begin
      if (state == IDLE && req_valid && reqReady) begin
        rf_readRegA <= req_rs;
        rf_readRegB <= req_rt;
      end
      if (state == READ) begin
        opA <= nextA;
        opB <= nextB;
      end
      wbPend.vld <= wbTake;
      if (wbTake) begin
        wbPend.rd   <= wb_reg;
        wbPend.data <= wb_data;
      end
    end
  end

  assign req_ready    = reqReady;
  assign op_valid     = (state == CAPT);
  assign rf_RegRead   = (state == READ);
  assign rf_writeReg  = wbPend.rd;
  assign rf_writeData = wbPend.data;
  assign rf_RegWrite  = wbPend.vld;

endmodule

// File: tb/tb_regfile_port_ctrl.sv
// Bench for regfile_port_ctrl: behavioural register file on the rf_* ports and an architectural register model for expected operands.
module tb_regfile_port_ctrl;
  localparam int AW = 5;
  localparam int DW = 32;
  localparam int NR = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid, req_ready, op_valid, op_ready;
  logic [AW-1:0] req_rs, req_rt, wb_reg;
  logic [DW-1:0] opA, opB, wb_data;
  logic          wb_valid;
  logic [AW-1:0] rf_readRegA, rf_readRegB, rf_writeReg;
  logic          rf_RegRead, rf_RegWrite;
  logic [DW-1:0] rf_regA, rf_regB, rf_writeData;

  int checks = 0;
  int errors = 0;

  logic          memInit;
  logic [DW-1:0] initVals [NR];
  logic [DW-1:0] rfMem    [NR];
  logic [DW-1:0] arch     [NR];
  logic [AW-1:0] burstR   [8];
  logic [DW-1:0] burstD   [8];

  always #5 clk = ~clk;

  regfile_port_ctrl #(.ADDR_W(AW), .DATA_W(DW), .NUM_REGS(NR)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_rs(req_rs), .req_rt(req_rt),
    .op_valid(op_valid), .op_ready(op_ready), .opA(opA), .opB(opB),
    .wb_valid(wb_valid), .wb_reg(wb_reg), .wb_data(wb_data),
    .rf_readRegA(rf_readRegA), .rf_readRegB(rf_readRegB), .rf_RegRead(rf_RegRead),
    .rf_regA(rf_regA), .rf_regB(rf_regB),
    .rf_writeReg(rf_writeReg), .rf_writeData(rf_writeData), .rf_RegWrite(rf_RegWrite)
  );

  // Register file: commits on the rising edge, reads on the falling edge, returns noise when not reading.
  // Entry 0 holds garbage so only the controller's $0 handling can produce zero.
  always @(posedge clk) begin
    if (memInit) for (int i = 0; i < NR; i++) rfMem[i] <= initVals[i];
    else if (rf_RegWrite) rfMem[rf_writeReg] <= rf_writeData;
  end

  always @(negedge clk) begin
    if (rf_RegRead) begin
      rf_regA <= rfMem[rf_readRegA];
      rf_regB <= rfMem[rf_readRegB];
    end else begin
      rf_regA <= $urandom;
      rf_regB <= $urandom;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic checkWb(input int j);
    chk("wb_en", 32'(rf_RegWrite), 32'(burstR[j] != '0));
    if (burstR[j] != '0) begin
      chk("wb_addr", 32'(rf_writeReg), 32'(burstR[j]));
      chk("wb_data", rf_writeData, burstD[j]);
    end
  endtask

  // Consecutive writeback pulses, one per cycle, from burstR/burstD.
  task automatic doWbBurst(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      wb_valid = 1'b1; wb_reg = burstR[i]; wb_data = burstD[i];
      if (burstR[i] != '0) arch[burstR[i]] = burstD[i];
      if (i > 0) begin
        @(negedge clk);
        checkWb(i - 1);
      end
    end
    @(posedge clk); #1;
    wb_valid = 1'b0;
    @(negedge clk);
    checkWb(n - 1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("wb_idle", 32'(rf_RegWrite), 32'd0);
  endtask

  // One operand fetch, optionally with a writeback in the first request cycle; op_ready held low for `hold` CAPT cycles.
  task automatic doReq(input logic [AW-1:0] rs, input logic [AW-1:0] rt, input bit wbV,
                       input logic [AW-1:0] wbR, input logic [DW-1:0] wbD, input int hold, input bit noisyWb);
    logic [DW-1:0] expA, expB;
    int stalls, expStalls;
    bit acc;
    @(posedge clk); #1;
    req_valid = 1'b1; req_rs = rs; req_rt = rt; op_ready = 1'b0;
    wb_valid = wbV; wb_reg = wbR; wb_data = wbD;
    if (wbV && wbR != '0) arch[wbR] = wbD;
    stalls = 0; acc = 1'b0; expA = '0; expB = '0;
    for (int k = 0; k < 8 && !acc; k++) begin
      @(negedge clk);
      if (req_ready === 1'b1) begin
        acc = 1'b1;
        expA = arch[rs];
        expB = arch[rt];
        chk("idle_rden", 32'(rf_RegRead), 32'd0);
      end else stalls++;
      @(posedge clk); #1;
      wb_valid = 1'b0;
    end
    req_valid = 1'b0;
    chk("accept", 32'(acc), 32'd1);
`ifdef REGFILE_FWD_EN
    expStalls = 0;
`else
    expStalls = (wbV && wbR != '0 && (wbR == rs || wbR == rt)) ? 1 : 0;
`endif
    chk("stall_cycles", 32'(stalls), 32'(expStalls));
    @(negedge clk);
    chk("read_en", 32'(rf_RegRead), 32'd1);
    chk("read_rdy", 32'(req_ready), 32'd0);
    chk("read_opv", 32'(op_valid), 32'd0);
    chk("read_addrA", 32'(rf_readRegA), 32'(rs));
    chk("read_addrB", 32'(rf_readRegB), 32'(rt));
    @(posedge clk); #1;
    op_ready = (hold == 0);
    @(negedge clk);
    chk("capt_opv", 32'(op_valid), 32'd1);
    chk("capt_opA", opA, expA);
    chk("capt_opB", opB, expB);
    chk("capt_rden", 32'(rf_RegRead), 32'd0);
    chk("capt_rdy", 32'(req_ready), 32'd0);
    for (int i = 1; i <= hold; i++) begin
      @(posedge clk); #1;
      op_ready = (i == hold);
      if (noisyWb) begin
        wb_valid = 1'b1; wb_reg = 5'($urandom); wb_data = $urandom;
        if (wb_reg != '0) arch[wb_reg] = wb_data;
      end
      @(negedge clk);
      chk("hold_opv", 32'(op_valid), 32'd1);
      chk("hold_opA", opA, expA);
      chk("hold_opB", opB, expB);
      chk("hold_rdy", 32'(req_ready), 32'd0);
    end
    @(posedge clk); #1;
    op_ready = 1'b0; wb_valid = 1'b0;
    @(negedge clk);
    chk("done_opv", 32'(op_valid), 32'd0);
    chk("done_rdy", 32'(req_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [AW-1:0] rs, rt, wr;
    int nb;
    rst = 1'b1; memInit = 1'b1;
    req_valid = 1'b0; req_rs = '0; req_rt = '0; op_ready = 1'b0;
    wb_valid = 1'b0; wb_reg = '0; wb_data = '0;
    for (int i = 0; i < NR; i++) begin
      initVals[i] = $urandom;
      arch[i]     = initVals[i];
    end
    initVals[0] = 32'hBAD0_0BAD;
    arch[0]     = '0;

    repeat (2) @(posedge clk);
    #1 memInit = 1'b0;
    @(negedge clk);
    chk("rst_rdy", 32'(req_ready), 32'd1);
    chk("rst_opv", 32'(op_valid), 32'd0);
    chk("rst_opA", opA, 32'd0);
    chk("rst_opB", opB, 32'd0);
    chk("rst_rden", 32'(rf_RegRead), 32'd0);
    chk("rst_wren", 32'(rf_RegWrite), 32'd0);
    chk("rst_raddr", 32'({rf_readRegA, rf_readRegB, rf_writeReg}), 32'd0);
    chk("rst_wdata", rf_writeData, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // $5 write, two idle cycles, then read $5/$0
    burstR[0] = 5'd5; burstD[0] = 32'h0000_1234;
    doWbBurst(1);
    repeat (2) @(posedge clk);
    doReq(5'd5, 5'd0, 1'b0, 5'd0, 32'd0, 0, 1'b0);

    // writes to $0 are dropped and $0 always reads as zero
    burstR[0] = 5'd0; burstD[0] = 32'hFFFF_FFFF;
    doWbBurst(1);
    doReq(5'd0, 5'd0, 1'b0, 5'd0, 32'd0, 0, 1'b0);

    // writeback to $7 in the request cycle: forwarded, or stalled one cycle
    doReq(5'd7, 5'd7, 1'b1, 5'd7, 32'hDEAD_BEEF, 0, 1'b0);

    // execute stalls five cycles
    doReq(5'd9, 5'd10, 1'b0, 5'd0, 32'd0, 5, 1'b0);

    // reset during READ while a $3 writeback arrives: the write is lost
    @(posedge clk); #1;
    req_valid = 1'b1; req_rs = 5'd3; req_rt = 5'd3;
    @(negedge clk);
    chk("rstmid_acc", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0; rst = 1'b1;
    wb_valid = 1'b1; wb_reg = 5'd3; wb_data = 32'h3333_3333;
    @(negedge clk);
    chk("rstmid_inread", 32'(rf_RegRead), 32'd1);
    @(posedge clk); #1;
    rst = 1'b0; wb_valid = 1'b0;
    @(negedge clk);
    chk("rstmid_opv", 32'(op_valid), 32'd0);
    chk("rstmid_rdy", 32'(req_ready), 32'd1);
    chk("rstmid_wren", 32'(rf_RegWrite), 32'd0);
    chk("rstmid_rden", 32'(rf_RegRead), 32'd0);
    doReq(5'd3, 5'd3, 1'b0, 5'd0, 32'd0, 0, 1'b0);

    // back-to-back writebacks
    burstR[0] = 5'd1; burstD[0] = 32'd1;
    burstR[1] = 5'd2; burstD[1] = 32'd2;
    burstR[2] = 5'd3; burstD[2] = 32'd3;
    doWbBurst(3);
    doReq(5'd1, 5'd3, 1'b0, 5'd0, 32'd0, 0, 1'b0);

    // random mix of writeback bursts, fetches with same-cycle writes, and stalls with writes during CAPT
    for (int it = 0; it < 40; it++) begin
      nb = $urandom_range(0, 3);
      for (int j = 0; j < nb; j++) begin
        burstR[j] = 5'($urandom);
        burstD[j] = $urandom;
      end
      if (nb > 0) doWbBurst(nb);
      rs = 5'($urandom);
      rt = ($urandom_range(0, 3) == 0) ? rs : 5'($urandom);
      wr = ($urandom_range(0, 1) == 1) ? (($urandom_range(0, 1) == 1) ? rs : rt) : 5'($urandom);
      doReq(rs, rt, 1'($urandom), wr, $urandom, $urandom_range(0, 3), 1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
